// File: rtl/hazard_unit_mc.sv
// Hazard controller for the 5-stage pipeline: E-stage forwarding, load-use stall,
// branch flush, one-entry MDU scoreboard and a whole-pipeline freeze on data-memory wait.
module hazard_unit_mc #(
  parameter int unsigned          REG_AW   = 5,
  parameter int unsigned          RESSRC_W = 3,
  parameter logic [RESSRC_W-1:0]  LOAD_SRC = 3'b001,
  parameter int unsigned          MDU_LAT  = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                RegwriteE,
  input  logic                RegwriteM,
  input  logic                RegwriteW,
  input  logic [REG_AW-1:0]   Rs1D,
  input  logic [REG_AW-1:0]   Rs2D,
  input  logic [REG_AW-1:0]   RdD,
  input  logic [REG_AW-1:0]   Rs1E,
  input  logic [REG_AW-1:0]   Rs2E,
  input  logic [REG_AW-1:0]   RdE,
  input  logic [REG_AW-1:0]   RdM,
  input  logic [REG_AW-1:0]   RdW,
  input  logic                mduD,
  input  logic                mduE,
  input  logic [RESSRC_W-1:0] resultsrcE,
  input  logic [1:0]          pcsrcE,
  input  logic                memreqM,
  input  logic                dmem_ready,
  output logic [1:0]          forwardAE,
  output logic [1:0]          forwardBE,
  output logic                stallF,
  output logic                stallD,
  output logic                stallE,
  output logic                stallM,
  output logic                flushD,
  output logic                flushE,
  output logic                flushW,
  output logic                mdu_busy,
  output logic                mdu_wb_valid,
  output logic [REG_AW-1:0]   mdu_wb_rd
);

  localparam int unsigned     CntW    = (MDU_LAT > 2) ? $clog2(MDU_LAT) : 1;
  localparam logic [CntW-1:0] CntInit = CntW'(MDU_LAT - 1);

  logic              busy_q, busy_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [REG_AW-1:0] rd_q, rd_d;

  logic memstall, br_taken, issue, lwstall, mdu_haz, dstall;
  logic dep_busy, dep_issue;

  // Forward select per source operand; M beats W, x0 never forwards.
  always_comb begin
    forwardAE = 2'b00;
    forwardBE = 2'b00;
    if (RegwriteM && (RdM == Rs1E) && (Rs1E != '0)) begin
      forwardAE = 2'b10;
    end else if (RegwriteW && (RdW == Rs1E) && (Rs1E != '0)) begin
      forwardAE = 2'b01;
    end
    if (RegwriteM && (RdM == Rs2E) && (Rs2E != '0)) begin
      forwardBE = 2'b10;
    end else if (RegwriteW && (RdW == Rs2E) && (Rs2E != '0)) begin
      forwardBE = 2'b01;
    end
  end

  // Hazard causes; a memory wait masks every D-stall cause and every flush into D/E.
  always_comb begin
    memstall  = memreqM & ~dmem_ready;
    br_taken  = (pcsrcE != 2'b00);
    issue     = mduE & RegwriteE & (RdE != '0) & ~memstall;
    lwstall   = (resultsrcE == LOAD_SRC) & RegwriteE & (RdE != '0) &
                ((Rs1D == RdE) | (Rs2D == RdE));
    dep_busy  = busy_q & (rd_q != '0) &
                ((Rs1D == rd_q) | (Rs2D == rd_q) | (RdD == rd_q));
    dep_issue = issue & ((Rs1D == RdE) | (Rs2D == RdE) | (RdD == RdE));
    // mduD & (busy | issue) is the structural stall keeping one op in flight.
    mdu_haz   = dep_busy | (mduD & (busy_q | issue)) | dep_issue;
    dstall    = (lwstall | mdu_haz) & ~memstall;
  end

  // Stall and flush outputs.
  always_comb begin
    stallF = dstall | memstall;
    stallD = dstall | memstall;
    stallE = memstall;
    stallM = memstall;
    flushW = memstall;
    flushD = br_taken & ~memstall;
    flushE = dstall | (br_taken & ~memstall);
  end

  // Scoreboard next state: load on issue, count down while busy, drop after the pulse.
  always_comb begin
    busy_d = busy_q;
    cnt_d  = cnt_q;
    rd_d   = rd_q;
    if (issue) begin
      busy_d = 1'b1;
      cnt_d  = CntInit;
      rd_d   = RdE;
    end else if (busy_q) begin
      if (cnt_q != '0) begin
        cnt_d = cnt_q - 1'b1;
      end else begin
        busy_d = 1'b0;
      end
    end
  end

  // Scoreboard state register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      rd_q   <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      rd_q   <= rd_d;
    end
  end

  // Scoreboard-derived outputs.
  always_comb begin
    mdu_busy     = busy_q;
    mdu_wb_valid = busy_q & (cnt_q == '0);
    mdu_wb_rd    = rd_q;
  end

endmodule
